// File: rtl/cs_pkg.sv
// cs_pkg: mode encodings, FSM state type and accumulator sizing shared by the
// cs_stream_ip checksum block and its beat reducer.
package cs_pkg;

    localparam logic CS_MODE_SUM = 1'b0;
    localparam logic CS_MODE_XOR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD1 = 2'd1,
        FOLD2 = 2'd2,
        DONE  = 2'd3
    } cs_state_e;

    // Headroom so a full packet of segment sums never wraps before folding.
    function automatic int csAccWidth(input int widthSeg, input int nSeg, input int maxBeats);
        return widthSeg + $clog2(nSeg * maxBeats);
    endfunction

endpackage

// File: rtl/cs_beat_reduce.sv
// cs_beat_reduce: combinational reduction of one beat into the zero-extended
// sum of its segments and the XOR of its segments.
module cs_beat_reduce
    import cs_pkg::*;
#(
    parameter int WIDTH_DATA = 256,
    parameter int WIDTH_SEG  = 16,
    parameter int ACC_W      = 22
) (
    input  logic [WIDTH_DATA-1:0] i_data,
    output logic [ACC_W-1:0]      o_sum,
    output logic [WIDTH_SEG-1:0]  o_xor
);

    localparam int NSEG = WIDTH_DATA / WIDTH_SEG;

    always_comb begin
        o_sum = '0;
        o_xor = '0;
        for (int k = 0; k < NSEG; k++) begin
            o_sum = o_sum + ACC_W'(i_data[k*WIDTH_SEG +: WIDTH_SEG]);
            o_xor = o_xor ^ i_data[k*WIDTH_SEG +: WIDTH_SEG];
        end
    end

endmodule

// File: rtl/cs_stream_ip.sv
// cs_stream_ip: multi-beat ones'-complement / XOR checksum with overrun detection.
// Define CS_ERR_CNT_EN to add the saturating err_cnt output.
module cs_stream_ip
    import cs_pkg::*;
#(
    parameter int WIDTH_DATA = 256,
    parameter int WIDTH_SEG  = 16,
    parameter int MAX_BEATS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  in_mode,
    input  logic [WIDTH_DATA-1:0] data,
    output logic                  out_valid,
    output logic [WIDTH_SEG-1:0]  out_sum,
    output logic                  result,
    output logic                  out_err
`ifdef CS_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int NSEG  = WIDTH_DATA / WIDTH_SEG;
    localparam int ACC_W = csAccWidth(WIDTH_SEG, NSEG, MAX_BEATS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    if (WIDTH_DATA % WIDTH_SEG != 0) begin : g_badDataWidth
        $error("cs_stream_ip: WIDTH_DATA must be a multiple of WIDTH_SEG");
    end
    if (ACC_W > 2 * WIDTH_SEG) begin : g_badAccWidth
        $error("cs_stream_ip: accumulator too wide for a two-step fold");
    end
    if (MAX_BEATS < 1) begin : g_badMaxBeats
        $error("cs_stream_ip: MAX_BEATS must be at least 1");
    end

    cs_state_e             r_state, w_nextState;
    logic [ACC_W-1:0]      r_acc, w_beatSum, w_beatVal, w_fold;
    logic [WIDTH_SEG-1:0]  w_beatXor, w_final, r_outSum;
    logic [CNT_W-1:0]      r_beatCnt;
    logic                  r_mode, r_errFlag, r_outValid, r_result, r_outErr;
    logic                  w_accept, w_firstBeat, w_curMode, w_lastCount, w_pktEnd;
    logic                  w_done, w_pass;

    cs_beat_reduce #(
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH_SEG  (WIDTH_SEG),
        .ACC_W      (ACC_W)
    ) u_reduce (
        .i_data (data),
        .o_sum  (w_beatSum),
        .o_xor  (w_beatXor)
    );

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_firstBeat = (r_beatCnt == '0);
    assign w_curMode   = w_firstBeat ? in_mode : r_mode;
    assign w_lastCount = (r_beatCnt == CNT_W'(MAX_BEATS - 1));
    assign w_pktEnd    = w_accept && (in_last || w_lastCount);
    assign w_beatVal   = (w_curMode == CS_MODE_XOR) ? ACC_W'(w_beatXor) : w_beatSum;
    // End-around carry: two passes always leave the upper bits clear.
    assign w_fold      = ACC_W'(r_acc[WIDTH_SEG-1:0]) + (r_acc >> WIDTH_SEG);
    assign w_final     = r_acc[WIDTH_SEG-1:0];
    assign w_pass      = (r_mode == CS_MODE_XOR) ? (w_final == '0) : (w_final == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_pktEnd) w_nextState = FOLD1;
            end
            FOLD1:   w_nextState = FOLD2;
            FOLD2:   w_nextState = DONE;
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_beatCnt <= '0;
            r_mode    <= CS_MODE_SUM;
            r_errFlag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_beatCnt <= r_beatCnt + CNT_W'(1);
                    if (w_firstBeat) begin
                        r_acc  <= w_beatVal;
                        r_mode <= in_mode;
                    end else if (r_mode == CS_MODE_XOR) begin
                        r_acc <= r_acc ^ w_beatVal;
                    end else begin
                        r_acc <= r_acc + w_beatVal;
                    end
                    if (w_pktEnd) r_errFlag <= !in_last;
                end
                FOLD1, FOLD2: if (r_mode == CS_MODE_SUM) r_acc <= w_fold;
                DONE:    r_beatCnt <= '0;
                default: ;
            endcase
        end
    end

    // Result registers are loaded only in DONE and hold until the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outSum   <= '0;
            r_result   <= 1'b0;
            r_outErr   <= 1'b0;
        end else begin
            r_outValid <= w_done;
            if (w_done) begin
                r_outSum <= (r_mode == CS_MODE_XOR) ? w_final : ~w_final;
                r_result <= w_pass;
                r_outErr <= r_errFlag;
            end
        end
    end

`ifdef CS_ERR_CNT_EN
    logic [7:0] r_errCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= '0;
        end else if (w_done && (!w_pass || r_errFlag) && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt = r_errCnt;
`endif

    assign out_valid = r_outValid;
    assign out_sum   = r_outSum;
    assign result    = r_result;
    assign out_err   = r_outErr;

endmodule

// File: tb/tb_cs_stream_ip.sv
// tb_cs_stream_ip: vector table, directed corner sequences and a randomized
// beat stream scored against a packet-level checksum model.
module tb_cs_stream_ip;

    localparam int WD = 256;
    localparam int WS = 16;
    localparam int MB = 4;
    localparam int NS = WD / WS;

    typedef struct {
        logic [WS-1:0] sum;
        logic          res;
        logic          err;
    } expRec_t;

    typedef struct {
        int            nBeats;
        logic [WD-1:0] beat;
        logic          mode;
        logic          lastOnFinal;
        logic [WS-1:0] expSum;
        logic          expRes;
        logic          expErr;
    } vector_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last, in_mode;
    logic [WD-1:0] data;
    logic          out_valid;
    logic [WS-1:0] out_sum;
    logic          result, out_err;
`ifdef CS_ERR_CNT_EN
    logic [7:0]    err_cnt;
    int            expErrCnt = 0;
`endif

    int      nChecks = 0;
    int      nFails  = 0;
    expRec_t expQ[$];

    cs_stream_ip #(
        .WIDTH_DATA (WD),
        .WIDTH_SEG  (WS),
        .MAX_BEATS  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .data      (data),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .result    (result),
        .out_err   (out_err)
`ifdef CS_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Packet-level model: total of every segment with end-around carry, or plain XOR.
    function automatic expRec_t modelPacket(input logic [WD-1:0] beats[$], input logic mode, input logic err);
        expRec_t       r;
        longint        s = 0;
        logic [WS-1:0] x = '0;
        logic [WD-1:0] bt;
        logic [WS-1:0] f;
        foreach (beats[b]) begin
            bt = beats[b];
            for (int k = 0; k < NS; k++) begin
                s = s + longint'(bt[k*WS +: WS]);
                x = x ^ bt[k*WS +: WS];
            end
        end
        while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
        f = s[WS-1:0];
        if (mode) begin
            r.sum = x;
            r.res = (x == '0);
        end else begin
            r.sum = ~f;
            r.res = (f == 16'hFFFF);
        end
        r.err = err;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_valid: got out_valid=1, expected no result");
            end else begin
                expRec_t e;
                e = expQ.pop_front();
                checkOutput("out_sum", 32'(out_sum), 32'(e.sum));
                checkOutput("result", 32'(result), 32'(e.res));
                checkOutput("out_err", 32'(out_err), 32'(e.err));
`ifdef CS_ERR_CNT_EN
                if ((!e.res || e.err) && expErrCnt < 255) expErrCnt++;
                checkOutput("err_cnt", 32'(err_cnt), 32'(expErrCnt));
`endif
            end
        end
    end

    task automatic sendBeat(input logic [WD-1:0] d, input logic m, input logic l, output logic wasReady);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        data     = d;
        in_mode  = m;
        in_last  = l;
        wasReady = in_ready;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Called right after the packet-ending edge: DONE registers the result one edge later.
    task automatic waitOut(input string tag);
        int cyc      = 1;
        int lowReady = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cyc < 12) begin
            if (!in_ready) lowReady++;
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd4);
        checkOutput({tag, "_ready_low"}, 32'(lowReady), 32'd3);
        @(negedge clk);
        checkOutput({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        logic rdy;
        expQ.push_back(expRec_t'{v.expSum, v.expRes, v.expErr});
        for (int b = 0; b < v.nBeats; b++)
            sendBeat(v.beat, v.mode, v.lastOnFinal && (b == v.nBeats - 1), rdy);
        waitOut($sformatf("vec%0d", idx));
    endtask

    initial begin
        vector_t       vecs[9];
        logic [WD-1:0] b, b5;
        logic [WD-1:0] pkt[$];
        logic          rdy, m, l, pmode;
        int            seenValid;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; data = '0;

        b = '0;
        vecs[0] = '{1, b, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        for (int k = 0; k < 15; k++) b[k*WS +: WS] = 16'h0001;
        b[15*WS +: WS] = 16'hFFF0;
        vecs[1] = '{1, b, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        b = '0; b[0 +: WS] = 16'hFFFF; b[WS +: WS] = 16'h0002;
        vecs[2] = '{1, b, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        b = '1;
        vecs[3] = '{4, b, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        b = '0; b[0 +: WS] = 16'hA5A5; b[WS +: WS] = 16'hA5A5;
        vecs[4] = '{1, b, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        b = '0; b[0 +: WS] = 16'h1234; b[3*WS +: WS] = 16'h00FF;
        vecs[5] = '{1, b, 1'b1, 1'b1, 16'h12CB, 1'b0, 1'b0};
        vecs[6] = '{3, b, 1'b1, 1'b1, 16'h12CB, 1'b0, 1'b0};
        b = '0;
        vecs[7] = '{4, b, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        b = '0; b[0 +: WS] = 16'h8000;
        vecs[8] = '{2, b, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        $display("[TB] overrun sequence");
        b  = '0; b[0 +: WS]  = 16'h0100;
        b5 = '0; b5[0 +: WS] = 16'hFFFE;
        expQ.push_back(expRec_t'{16'hFBFF, 1'b0, 1'b1});
        expQ.push_back(expRec_t'{16'h0001, 1'b0, 1'b0});
        for (int i = 0; i < MB; i++) sendBeat(b, 1'b0, 1'b0, rdy);
        sendBeat(b5, 1'b0, 1'b1, rdy);
        checkOutput("overrun_fifth_ready", 32'(rdy), 32'd0);
        waitOut("overrun_next");

        $display("[TB] random stream");
        pmode = 1'b0;
        for (int i = 0; i < 48; i++) begin
            for (int k = 0; k < NS; k++)
                b[k*WS +: WS] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            m = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 2) == 0) || (i == 47);
            if (pkt.size() == 0) pmode = m;
            pkt.push_back(b);
            if (l || pkt.size() == MB) begin
                expQ.push_back(modelPacket(pkt, pmode, !l));
                pkt.delete();
            end
            sendBeat(b, m, l, rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("[TB] reset during packet");
        b = '0; b[0 +: WS] = 16'hA5A5; b[WS +: WS] = 16'hA5A5;
        expQ.push_back(expRec_t'{16'h0000, 1'b1, 1'b0});
        sendBeat(b, 1'b1, 1'b1, rdy);
        waitOut("xor_pkt");
        for (int i = 0; i < 2; i++) sendBeat({8{32'($urandom)}}, 1'b1, 1'b0, rdy);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CS_ERR_CNT_EN
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        expErrCnt = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seenValid = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seenValid++;
        end
        checkOutput("no_valid_after_reset", 32'(seenValid), 32'd0);

        b = '0; b[0 +: WS] = 16'h0001;
        expQ.push_back(expRec_t'{16'hFFFE, 1'b0, 1'b0});
        sendBeat(b, 1'b0, 1'b1, rdy);
        waitOut("post_reset");

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
